// File: rtl/fault_pkg.sv
// Shared types and constants for the fault diagnoser: fault-type encoding,
// diagnosis status codes and controller states.
package fault_pkg;

  localparam int DATA_W = 8;
  localparam int LOC_W  = 3;

  // Matches the encoding the fault injector uses for f_type.
  typedef enum logic [1:0] {
    F_NONE = 2'b00,
    F_SA0  = 2'b01,
    F_SA1  = 2'b10,
    F_FLIP = 2'b11
  } f_type_t;

  typedef enum logic [1:0] {
    DS_NO_FAULT  = 2'b00,
    DS_SINGLE    = 2'b01,
    DS_MULTI     = 2'b10,
    DS_AMBIGUOUS = 2'b11
  } diag_status_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SCAN,
    REPORT
  } fd_state_t;

endpackage

// File: rtl/fd_bit_tracker.sv
// Sticky evidence for one output bit across a sample window, plus the
// combinational classification of that evidence into a fault class.
module fd_bit_tracker
  import fault_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sample_en,
  input  logic       exp_b,
  input  logic       obs_b,
  output logic       faulty,
  output logic       unresolved,
  output logic [1:0] ftype
);

  logic s0, s1, m0, m1, k0, k1;
  logic is_sa0, is_sa1, is_flip;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      m0 <= 1'b0;
      m1 <= 1'b0;
      k0 <= 1'b0;
      k1 <= 1'b0;
    end else if (sample_en) begin
      if (exp_b) begin
        s1 <= 1'b1;
        if (obs_b) k1 <= 1'b1;
        else       m1 <= 1'b1;
      end else begin
        s0 <= 1'b1;
        if (obs_b) m0 <= 1'b1;
        else       k0 <= 1'b1;
      end
    end
  end

  // Anything faulty that fits none of the three clean signatures is either
  // intermittent or lacks the opposite expected value to tell SA from FLIP.
  always_comb begin
    is_sa1     = m0 & ~k0 & ~m1 & s1;
    is_sa0     = m1 & ~k1 & ~m0 & s0;
    is_flip    = m0 & m1 & ~k0 & ~k1;
    faulty     = m0 | m1;
    unresolved = faulty & ~(is_sa0 | is_sa1 | is_flip);
    ftype      = F_NONE;
    if (is_sa0)       ftype = F_SA0;
    else if (is_sa1)  ftype = F_SA1;
    else if (is_flip) ftype = F_FLIP;
  end

endmodule

// File: rtl/fault_diagnoser.sv
// Infers the injected fault from (expected, observed) sample pairs over a window.
// Optional FD_FIRST_ERR_LOG_EN adds a log of the first mismatching sample.
module fault_diagnoser
  import fault_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] exp_y,
  input  logic [DATA_W-1:0] obs_y,
  output logic              diag_valid,
  input  logic              diag_ack,
  output logic [LOC_W-1:0]  diag_loc,
  output logic [1:0]        diag_type,
  output logic [1:0]        diag_status,
  output logic [CNT_W-1:0]  err_count
`ifdef FD_FIRST_ERR_LOG_EN
  ,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_vec,
  output logic              first_err_seen
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [LOC_W-1:0] LAST_BIT = LOC_W'(DATA_W - 1);

  fd_state_t         state, next_state;
  logic [CNT_W-1:0]  sample_cnt;
  logic [LOC_W-1:0]  scan_idx;
  logic [1:0]        nfault, nfault_nxt;
  logic [LOC_W-1:0]  sel_loc, loc_nxt;
  logic [1:0]        sel_type, type_nxt;
  logic              sel_unres, unres_nxt;
  logic [1:0]        status_nxt;
  logic              accept, clear_ev, last_accept;
  logic              cur_faulty, cur_unres;
  logic [1:0]        cur_type;

  logic [DATA_W-1:0] bit_faulty, bit_unres;
  logic [1:0]        bit_type [DATA_W];

  assign in_ready    = (state == COLLECT);
  assign diag_valid  = (state == REPORT);
  assign accept      = in_valid & in_ready;
  assign clear_ev    = (state == IDLE) & start;
  assign last_accept = accept & (sample_cnt == LAST_IDX);

  for (genvar g = 0; g < DATA_W; g++) begin : g_trk
    fd_bit_tracker u_trk (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_ev),
      .sample_en  (accept),
      .exp_b      (exp_y[g]),
      .obs_b      (obs_y[g]),
      .faulty     (bit_faulty[g]),
      .unresolved (bit_unres[g]),
      .ftype      (bit_type[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COLLECT;
      COLLECT: if (last_accept) next_state = SCAN;
      SCAN:    if (scan_idx == LAST_BIT) next_state = REPORT;
      REPORT:  if (diag_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Scan step: the first faulty bit seen fixes loc/type; nfault saturates at 2.
  always_comb begin
    cur_faulty = bit_faulty[scan_idx];
    cur_unres  = bit_unres[scan_idx];
    cur_type   = bit_type[scan_idx];
    nfault_nxt = nfault;
    loc_nxt    = sel_loc;
    type_nxt   = sel_type;
    unres_nxt  = sel_unres;
    if (cur_faulty) begin
      if (nfault == 2'd0) begin
        loc_nxt   = scan_idx;
        type_nxt  = cur_unres ? F_NONE : cur_type;
        unres_nxt = cur_unres;
      end
      if (nfault != 2'd2) nfault_nxt = nfault + 2'd1;
    end
    if (nfault_nxt == 2'd0)      status_nxt = DS_NO_FAULT;
    else if (nfault_nxt == 2'd1) status_nxt = unres_nxt ? DS_AMBIGUOUS : DS_SINGLE;
    else                         status_nxt = DS_MULTI;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt  <= '0;
      err_count   <= '0;
      scan_idx    <= '0;
      nfault      <= '0;
      sel_loc     <= '0;
      sel_type    <= '0;
      sel_unres   <= 1'b0;
      diag_loc    <= '0;
      diag_type   <= '0;
      diag_status <= '0;
    end else begin
      if (clear_ev) begin
        sample_cnt <= '0;
        err_count  <= '0;
        scan_idx   <= '0;
        nfault     <= '0;
        sel_loc    <= '0;
        sel_type   <= '0;
        sel_unres  <= 1'b0;
      end
      if (accept) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        if ((exp_y != obs_y) && (err_count != '1))
          err_count <= err_count + CNT_W'(1);
      end
      if (state == SCAN) begin
        scan_idx  <= scan_idx + LOC_W'(1);
        nfault    <= nfault_nxt;
        sel_loc   <= loc_nxt;
        sel_type  <= type_nxt;
        sel_unres <= unres_nxt;
        if (scan_idx == LAST_BIT) begin
          diag_loc    <= loc_nxt;
          diag_type   <= type_nxt;
          diag_status <= status_nxt;
        end
      end
    end
  end

`ifdef FD_FIRST_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (reset || clear_ev) begin
      first_err_idx  <= '0;
      first_err_vec  <= '0;
      first_err_seen <= 1'b0;
    end else if (accept && (exp_y != obs_y) && !first_err_seen) begin
      first_err_idx  <= sample_cnt;
      first_err_vec  <= exp_y ^ obs_y;
      first_err_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fault_diagnoser.sv
// Directed bench for fault_diagnoser: a bench-side injector model feeds
// 64-sample windows and each scenario checks verdict, latency and handshake.
module tb_fault_diagnoser;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [7:0]  exp_y, obs_y;
  logic        diag_valid, diag_ack;
  logic [2:0]  diag_loc;
  logic [1:0]  diag_type, diag_status;
  logic [15:0] err_count;
`ifdef FD_FIRST_ERR_LOG_EN
  logic [15:0] first_err_idx;
  logic [7:0]  first_err_vec;
  logic        first_err_seen;
`endif

  int total = 0;
  int bad   = 0;
  int got_lat;
  int model_err;
  bit rdy_fell;

  fault_diagnoser #(.WINDOW(64), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .exp_y       (exp_y),
    .obs_y       (obs_y),
    .diag_valid  (diag_valid),
    .diag_ack    (diag_ack),
    .diag_loc    (diag_loc),
    .diag_type   (diag_type),
    .diag_status (diag_status),
    .err_count   (err_count)
`ifdef FD_FIRST_ERR_LOG_EN
    ,
    .first_err_idx  (first_err_idx),
    .first_err_vec  (first_err_vec),
    .first_err_seen (first_err_seen)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Injector model: apply fault type t at bit l to value y.
  function automatic logic [7:0] inject(input logic [7:0] y, input logic [2:0] l,
                                        input logic [1:0] t);
    logic [7:0] m;
    m = 8'd1 << l;
    case (t)
      2'd1:    return y & ~m;
      2'd2:    return y | m;
      2'd3:    return y ^ m;
      default: return y;
    endcase
  endfunction

  // Starts a window and feeds n accepted samples carrying up to two faults.
  // If wait_diag, measures cycles from the last accept cycle to diag_valid.
  task automatic run_window(input int n, input logic [2:0] la, input logic [1:0] ta,
                            input logic [2:0] lb, input logic [1:0] tb2,
                            input logic [7:0] mask, input bit gaps, input bit wait_diag);
    int i = 0;
    int guard = 0;
    int lat = 0;
    logic rdy;
    logic [7:0] e;
    model_err = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (i < n && guard < 4000) begin
      e        = 8'(i * 37 + 11) & mask;
      exp_y    = e;
      obs_y    = inject(inject(e, la, ta), lb, tb2);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy      = in_ready;
      @(posedge clk);
      if (in_valid && rdy) begin
        i++;
        if (exp_y != obs_y) model_err++;
      end
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rdy_fell = (in_ready === 1'b0);
    if (i < n) begin
      total++; bad++;
      $display("FAIL accept_budget: accepted %0d samples, needed %0d", i, n);
    end
    if (wait_diag) begin
      while (diag_valid !== 1'b1 && lat < 40) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      got_lat = lat + 1;
    end
  endtask

  task automatic do_ack();
    @(negedge clk) diag_ack = 1'b1;
    @(negedge clk) diag_ack = 1'b0;
  endtask

  // One full window scenario with its expected verdict; e_err < 0 uses the model count.
  task automatic test_window(input string name, input logic [2:0] la, input logic [1:0] ta,
                             input logic [2:0] lb, input logic [1:0] tb2,
                             input logic [7:0] mask, input bit gaps,
                             input logic [1:0] e_status, input logic [2:0] e_loc,
                             input logic [1:0] e_type, input int e_err);
    int want_err;
    run_window(64, la, ta, lb, tb2, mask, gaps, 1'b1);
    want_err = (e_err < 0) ? model_err : e_err;
    total++;
    if (!rdy_fell) begin
      bad++; $display("FAIL %s in_ready_fall: in_ready=%b after last accept, want 0", name, in_ready);
    end
    total++;
    if (got_lat != 9) begin
      bad++; $display("FAIL %s latency: got %0d cycles, want 9", name, got_lat);
    end
    total++;
    if ({diag_valid, diag_status, diag_loc, diag_type} !== {1'b1, e_status, e_loc, e_type}) begin
      bad++;
      $display("FAIL %s verdict: got valid=%b status=%0d loc=%0d type=%0d, want valid=1 status=%0d loc=%0d type=%0d",
               name, diag_valid, diag_status, diag_loc, diag_type, e_status, e_loc, e_type);
    end
    total++;
    if (err_count !== 16'(want_err)) begin
      bad++; $display("FAIL %s err_count: got %0d, want %0d", name, err_count, want_err);
    end
    do_ack();
    total++;
    if (diag_valid !== 1'b0) begin
      bad++; $display("FAIL %s ack: diag_valid=%b after ack, want 0", name, diag_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; diag_ack = 1'b0;
    exp_y = 8'h00; obs_y = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, diag_valid, diag_loc, diag_type, diag_status, err_count} !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b valid=%b loc=%0d type=%0d status=%0d err=%0d, want all 0",
               in_ready, diag_valid, diag_loc, diag_type, diag_status, err_count);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_ready: in_ready=%b in IDLE, want 0", in_ready);
    end
  endtask

  task automatic test_sa1_single();
    test_window("sa1_bit5", 3'd5, 2'd2, 3'd0, 2'd0, 8'hFF, 1'b0, 2'b01, 3'd5, 2'b10, -1);
  endtask

  task automatic test_flip_single();
    test_window("flip_bit2", 3'd2, 2'd3, 3'd0, 2'd0, 8'hFF, 1'b0, 2'b01, 3'd2, 2'b11, 64);
  endtask

  task automatic test_no_fault();
    test_window("no_fault", 3'd0, 2'd0, 3'd0, 2'd0, 8'hFF, 1'b0, 2'b00, 3'd0, 2'b00, 0);
  endtask

  task automatic test_multi();
    test_window("multi_3_6", 3'd3, 2'd1, 3'd6, 2'd2, 8'hFF, 1'b0, 2'b10, 3'd3, 2'b01, -1);
  endtask

  task automatic test_ambiguous();
    test_window("ambig", 3'd0, 2'd2, 3'd0, 2'd0, 8'hFE, 1'b0, 2'b11, 3'd0, 2'b00, 64);
    test_window("ambig_gaps", 3'd0, 2'd2, 3'd0, 2'd0, 8'hFE, 1'b1, 2'b11, 3'd0, 2'b00, 64);
  endtask

  task automatic test_reset_mid_window();
    bit seen_valid = 1'b0;
    run_window(30, 3'd5, 2'd2, 3'd0, 2'd0, 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    total++;
    if ({in_ready, diag_valid, err_count} !== 18'd0) begin
      bad++;
      $display("FAIL mid_reset_state: got rdy=%b valid=%b err=%0d, want 0 0 0", in_ready, diag_valid, err_count);
    end
    repeat (15) begin
      @(negedge clk);
      if (diag_valid === 1'b1) seen_valid = 1'b1;
    end
    total++;
    if (seen_valid) begin
      bad++; $display("FAIL mid_reset_report: diag_valid=1 after reset, want no report");
    end
    test_window("post_reset", 3'd0, 2'd0, 3'd0, 2'd0, 8'hFF, 1'b0, 2'b00, 3'd0, 2'b00, 0);
  endtask

  task automatic test_report_hold();
    run_window(64, 3'd5, 2'd2, 3'd0, 2'd0, 8'hFF, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      start = (c == 2);
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({diag_valid, in_ready, diag_status, diag_loc, diag_type} !== {1'b1, 1'b0, 2'b01, 3'd5, 2'b10}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got valid=%b rdy=%b status=%0d loc=%0d type=%0d, want 1 0 1 5 2",
                 c, diag_valid, in_ready, diag_status, diag_loc, diag_type);
      end
    end
    do_ack();
    total++;
    if (diag_valid !== 1'b0) begin
      bad++; $display("FAIL hold_ack: diag_valid=%b after ack, want 0", diag_valid);
    end
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL start_in_report: in_ready=%b after ack, want 0 (start must be ignored)", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_sa1_single();
    test_flip_single();
    test_no_fault();
    test_multi();
    test_ambiguous();
    test_reset_mid_window();
    test_report_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
